// File: rtl/morra_tabellone.sv
// morra_tabellone -- scoreboard stage behind the MorraCinese FSMD.
//
// Tracks the rounds of the current game (total, PRIMO wins, SECONDO wins,
// draws), latches the match result, and keeps a show-ahead FIFO of round
// outcomes for the display/readout logic.
//
// Optional feature: define MORRA_TOTALI_EN to add cross-game totals
// (PARTITE_P1 / PARTITE_P2 / PARTITE_PARI), cleared only by rst.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   INIZIO            new-game strobe (shared with the FSMD)
//   MANCHE[1:0]       round result: 00 none, 01 P1, 10 P2, 11 draw
//   PARTITA[1:0]      match result: 00 running, 01 P1, 10 P2, 11 tie
//   STORICO_POP       history read strobe
//   MANCHE_TOT, VITTORIE_P1, VITTORIE_P2, PAREGGI   per-game counters
//   RISULTATO         latched PARTITA code
//   FINE_PARTITA      high while the game is over
//   STORICO_DATO      FIFO head (00 when empty)
//   STORICO_VUOTO / STORICO_PIENO   FIFO empty / full
//   STORICO_PERSO     sticky: a push was dropped because the FIFO was full
module morra_tabellone #(
  parameter int CNT_W = 5,
  parameter int DEPTH = 16,
  parameter int TOT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIZIO,
  input  logic [1:0]       MANCHE,
  input  logic [1:0]       PARTITA,
  input  logic             STORICO_POP,
  output logic [CNT_W-1:0] MANCHE_TOT,
  output logic [CNT_W-1:0] VITTORIE_P1,
  output logic [CNT_W-1:0] VITTORIE_P2,
  output logic [CNT_W-1:0] PAREGGI,
  output logic [1:0]       RISULTATO,
  output logic             FINE_PARTITA,
  output logic [1:0]       STORICO_DATO,
  output logic             STORICO_VUOTO,
  output logic             STORICO_PIENO,
  output logic             STORICO_PERSO
`ifdef MORRA_TOTALI_EN
  ,
  output logic [TOT_W-1:0] PARTITE_P1,
  output logic [TOT_W-1:0] PARTITE_P2,
  output logic [TOT_W-1:0] PARTITE_PARI
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time guard: the pointer wrap relies on a power-of-two depth.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || TOT_W < 1) begin : g_bad_params
    $error("morra_tabellone: invalid parameters");
  end

  typedef enum logic [1:0] {IDLE, GIOCO, FINE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tot_q, p1_q, p2_q, pari_q;
  logic [1:0]       ris_q;
  logic             fine_q;
  logic [1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             perso_q;

  logic round_ok, pop_ok, push_ok, game_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // A round counts only in GIOCO and only when no restart is requested.
  assign round_ok = (state_q == GIOCO) && !INIZIO && (MANCHE != 2'b00);
  assign game_end = (state_q == GIOCO) && !INIZIO && (PARTITA != 2'b00);
  assign pop_ok   = STORICO_POP && (occ_q != '0);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok  = round_ok && ((occ_q != OCC_W'(DEPTH)) || pop_ok);

  always_comb begin
    occ_d = occ_q;
    if (push_ok && !pop_ok)
      occ_d = occ_q + OCC_W'(1);
    else if (!push_ok && pop_ok)
      occ_d = occ_q - OCC_W'(1);
  end

`ifdef MORRA_TOTALI_EN
  localparam logic [TOT_W-1:0] TOT_MAX = '1;
  logic [TOT_W-1:0] gp1_q, gp2_q, gpari_q;

  function automatic logic [TOT_W-1:0] sat_tot(input logic [TOT_W-1:0] v);
    return (v == TOT_MAX) ? v : v + TOT_W'(1);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tot_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      pari_q   <= '0;
      ris_q    <= 2'b00;
      fine_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      perso_q  <= 1'b0;
`ifdef MORRA_TOTALI_EN
      gp1_q    <= '0;
      gp2_q    <= '0;
      gpari_q  <= '0;
`endif
    end else if (INIZIO) begin
      // New game from any state; overrides same-cycle FIFO traffic.
      state_q  <= GIOCO;
      tot_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      pari_q   <= '0;
      ris_q    <= 2'b00;
      fine_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      perso_q  <= 1'b0;
    end else begin
      if (round_ok) begin
        tot_q <= sat_inc(tot_q);
        case (MANCHE)
          2'b01:   p1_q   <= sat_inc(p1_q);
          2'b10:   p2_q   <= sat_inc(p2_q);
          default: pari_q <= sat_inc(pari_q);
        endcase
        if (!push_ok)
          perso_q <= 1'b1;
      end
      if (game_end) begin
        state_q <= FINE;
        ris_q   <= PARTITA;
        fine_q  <= 1'b1;
`ifdef MORRA_TOTALI_EN
        case (PARTITA)
          2'b01:   gp1_q   <= sat_tot(gp1_q);
          2'b10:   gp2_q   <= sat_tot(gp2_q);
          default: gpari_q <= sat_tot(gpari_q);
        endcase
`endif
      end
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // History storage: no reset needed, validity is tracked by occ_q.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= MANCHE;
  end

  assign MANCHE_TOT    = tot_q;
  assign VITTORIE_P1   = p1_q;
  assign VITTORIE_P2   = p2_q;
  assign PAREGGI       = pari_q;
  assign RISULTATO     = ris_q;
  assign FINE_PARTITA  = fine_q;
  assign STORICO_VUOTO = (occ_q == '0);
  assign STORICO_PIENO = (occ_q == OCC_W'(DEPTH));
  assign STORICO_DATO  = (occ_q == '0) ? 2'b00 : mem_q[rd_ptr_q];
  assign STORICO_PERSO = perso_q;
`ifdef MORRA_TOTALI_EN
  assign PARTITE_P1    = gp1_q;
  assign PARTITE_P2    = gp2_q;
  assign PARTITE_PARI  = gpari_q;
`endif

endmodule

// File: tb/tb_morra_tabellone.sv
// Self-checking bench for morra_tabellone: directed vector table from the
// test plan, then randomized traffic against a queue-based reference model.
module tb_morra_tabellone;

  localparam int DEPTH_M = 4;
  localparam int CMAX    = 31;
`ifdef MORRA_TOTALI_EN
  localparam int TMAX    = 255;
`endif

  logic clk = 1'b0;
  logic rst, INIZIO, STORICO_POP;
  logic [1:0] MANCHE, PARTITA;

  logic [4:0] tot, p1, p2, pd;
  logic [1:0] ris, dato;
  logic fine, vuoto, pieno, perso;

  logic [1:0] s_tot, s_p1, s_p2, s_pd, s_ris, s_dato;
  logic s_fine, s_vuoto, s_pieno, s_perso;

`ifdef MORRA_TOTALI_EN
  logic [7:0] gp1, gp2, gpari, s_gp1, s_gp2, s_gpari;
`endif

  always #5 clk = ~clk;

  morra_tabellone #(.CNT_W(5), .DEPTH(DEPTH_M), .TOT_W(8)) dut (
    .clk(clk), .rst(rst), .INIZIO(INIZIO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .STORICO_POP(STORICO_POP), .MANCHE_TOT(tot), .VITTORIE_P1(p1),
    .VITTORIE_P2(p2), .PAREGGI(pd), .RISULTATO(ris), .FINE_PARTITA(fine),
    .STORICO_DATO(dato), .STORICO_VUOTO(vuoto), .STORICO_PIENO(pieno),
    .STORICO_PERSO(perso)
`ifdef MORRA_TOTALI_EN
    , .PARTITE_P1(gp1), .PARTITE_P2(gp2), .PARTITE_PARI(gpari)
`endif
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  morra_tabellone #(.CNT_W(2), .DEPTH(16), .TOT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .INIZIO(INIZIO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .STORICO_POP(STORICO_POP), .MANCHE_TOT(s_tot), .VITTORIE_P1(s_p1),
    .VITTORIE_P2(s_p2), .PAREGGI(s_pd), .RISULTATO(s_ris), .FINE_PARTITA(s_fine),
    .STORICO_DATO(s_dato), .STORICO_VUOTO(s_vuoto), .STORICO_PIENO(s_pieno),
    .STORICO_PERSO(s_perso)
`ifdef MORRA_TOTALI_EN
    , .PARTITE_P1(s_gp1), .PARTITE_P2(s_gp2), .PARTITE_PARI(s_gpari)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state;            // 0 idle, 1 playing, 2 game over
  int m_tot, m_p1, m_p2, m_pd, m_ris;
  bit m_fine, m_perso;
  logic [1:0] m_q[$];
`ifdef MORRA_TOTALI_EN
  int m_gp1, m_gp2, m_gpari;
`endif

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    m_tot = 0; m_p1 = 0; m_p2 = 0; m_pd = 0; m_ris = 0;
    m_fine = 0; m_perso = 0; m_q.delete();
  endtask

  task automatic model_step(input int r, input int ini, input int man,
                            input int par, input int pop);
    bit pop_ok;
    if (r != 0) begin
      m_state = 0;
      model_clear();
`ifdef MORRA_TOTALI_EN
      m_gp1 = 0; m_gp2 = 0; m_gpari = 0;
`endif
      return;
    end
    pop_ok = (pop != 0) && (m_q.size() > 0);
    if (ini != 0) begin
      m_state = 1;
      model_clear();
      return;
    end
    if (m_state == 1) begin
      if (man != 0) begin
        m_tot = sat(m_tot, CMAX);
        if (man == 1) m_p1 = sat(m_p1, CMAX);
        else if (man == 2) m_p2 = sat(m_p2, CMAX);
        else m_pd = sat(m_pd, CMAX);
        if (m_q.size() - (pop_ok ? 1 : 0) < DEPTH_M) m_q.push_back(2'(man));
        else m_perso = 1;
      end
      if (par != 0) begin
        m_ris = par; m_fine = 1; m_state = 2;
`ifdef MORRA_TOTALI_EN
        if (par == 1) m_gp1 = sat(m_gp1, TMAX);
        else if (par == 2) m_gp2 = sat(m_gp2, TMAX);
        else m_gpari = sat(m_gpari, TMAX);
`endif
      end
    end
    if (pop_ok) void'(m_q.pop_front());
  endtask

  // Drive one cycle, advance the model, and sample #1 after the edge.
  task automatic apply(input int r, input int ini, input int man,
                       input int par, input int pop);
    rst = (r != 0); INIZIO = (ini != 0); MANCHE = 2'(man);
    PARTITA = 2'(par); STORICO_POP = (pop != 0);
    model_step(r, ini, man, par, pop);
    @(posedge clk);
    #1;
    $display("T rst=%0d ini=%0d man=%0d par=%0d pop=%0d -> tot=%0d p1=%0d p2=%0d pd=%0d ris=%0d fine=%0d dato=%0d v=%0d f=%0d perso=%0d",
             r, ini, man, par, pop, tot, p1, p2, pd, ris, fine, dato, vuoto, pieno, perso);
  endtask

  task automatic check_model(input int n);
    chk($sformatf("rnd%0d tot", n), int'(tot), m_tot);
    chk($sformatf("rnd%0d p1", n), int'(p1), m_p1);
    chk($sformatf("rnd%0d p2", n), int'(p2), m_p2);
    chk($sformatf("rnd%0d pd", n), int'(pd), m_pd);
    chk($sformatf("rnd%0d ris", n), int'(ris), m_ris);
    chk($sformatf("rnd%0d fine", n), int'(fine), int'(m_fine));
    chk($sformatf("rnd%0d dato", n), int'(dato), (m_q.size() > 0) ? int'(m_q[0]) : 0);
    chk($sformatf("rnd%0d vuoto", n), int'(vuoto), (m_q.size() == 0) ? 1 : 0);
    chk($sformatf("rnd%0d pieno", n), int'(pieno), (m_q.size() == DEPTH_M) ? 1 : 0);
    chk($sformatf("rnd%0d perso", n), int'(perso), int'(m_perso));
`ifdef MORRA_TOTALI_EN
    chk($sformatf("rnd%0d gp1", n), int'(gp1), m_gp1);
    chk($sformatf("rnd%0d gp2", n), int'(gp2), m_gp2);
    chk($sformatf("rnd%0d gpari", n), int'(gpari), m_gpari);
`endif
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int r, ini, man, par, pop;
    int tot, p1, p2, pd, ris, fine, dato, vu, pi, pe;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // inputs: rst ini man par pop | expected: tot p1 p2 pd ris fine dato vuoto pieno perso
    tbl.push_back(vec_t'{1,0,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 0 reset
    tbl.push_back(vec_t'{1,0,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 1
    tbl.push_back(vec_t'{0,0,1,0,0, 0,0,0,0,0,0,0,1,0,0});  // 2 idle ignores rounds
    tbl.push_back(vec_t'{0,0,1,0,0, 0,0,0,0,0,0,0,1,0,0});  // 3
    tbl.push_back(vec_t'{0,0,1,0,0, 0,0,0,0,0,0,0,1,0,0});  // 4
    tbl.push_back(vec_t'{0,0,1,1,0, 0,0,0,0,0,0,0,1,0,0});  // 5 idle ignores result
    tbl.push_back(vec_t'{0,1,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 6 start
    tbl.push_back(vec_t'{0,0,2,0,0, 1,0,1,0,0,0,2,0,0,0});  // 7
    tbl.push_back(vec_t'{0,0,1,0,0, 2,1,1,0,0,0,2,0,0,0});  // 8
    tbl.push_back(vec_t'{0,0,1,0,0, 3,2,1,0,0,0,2,0,0,0});  // 9
    tbl.push_back(vec_t'{0,0,0,0,0, 3,2,1,0,0,0,2,0,0,0});  // 10 no round
    tbl.push_back(vec_t'{0,0,1,0,0, 4,3,1,0,0,0,2,0,1,0});  // 11 fifo full
    tbl.push_back(vec_t'{0,0,0,0,1, 4,3,1,0,0,0,1,0,0,0});  // 12 pop 10
    tbl.push_back(vec_t'{0,0,0,0,1, 4,3,1,0,0,0,1,0,0,0});  // 13
    tbl.push_back(vec_t'{0,0,0,0,1, 4,3,1,0,0,0,1,0,0,0});  // 14
    tbl.push_back(vec_t'{0,0,0,0,1, 4,3,1,0,0,0,0,1,0,0});  // 15 empty
    tbl.push_back(vec_t'{0,0,0,0,1, 4,3,1,0,0,0,0,1,0,0});  // 16 pop on empty
    tbl.push_back(vec_t'{0,0,1,1,0, 5,4,1,0,1,1,1,0,0,0});  // 17 round + end
    tbl.push_back(vec_t'{0,0,2,0,0, 5,4,1,0,1,1,1,0,0,0});  // 18 FINE ignores
    tbl.push_back(vec_t'{0,0,3,2,0, 5,4,1,0,1,1,1,0,0,0});  // 19
    tbl.push_back(vec_t'{0,1,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 20 restart from FINE
    tbl.push_back(vec_t'{0,0,3,0,0, 1,0,0,1,0,0,3,0,0,0});  // 21
    tbl.push_back(vec_t'{0,0,2,0,0, 2,0,1,1,0,0,3,0,0,0});  // 22
    tbl.push_back(vec_t'{0,0,1,0,0, 3,1,1,1,0,0,3,0,0,0});  // 23
    tbl.push_back(vec_t'{0,0,3,0,0, 4,1,1,2,0,0,3,0,1,0});  // 24 full
    tbl.push_back(vec_t'{0,0,2,0,0, 5,1,2,2,0,0,3,0,1,1});  // 25 dropped
    tbl.push_back(vec_t'{0,0,1,0,1, 6,2,2,2,0,0,2,0,1,1});  // 26 push+pop full
    tbl.push_back(vec_t'{0,0,0,0,1, 6,2,2,2,0,0,1,0,0,1});  // 27
    tbl.push_back(vec_t'{0,0,0,0,1, 6,2,2,2,0,0,3,0,0,1});  // 28
    tbl.push_back(vec_t'{0,0,0,0,1, 6,2,2,2,0,0,1,0,0,1});  // 29 appended entry
    tbl.push_back(vec_t'{0,0,0,0,1, 6,2,2,2,0,0,0,1,0,1});  // 30 perso sticky
    tbl.push_back(vec_t'{0,1,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 31 restart
    tbl.push_back(vec_t'{0,0,3,0,0, 1,0,0,1,0,0,3,0,0,0});  // 32 draws
    tbl.push_back(vec_t'{0,0,3,0,0, 2,0,0,2,0,0,3,0,0,0});  // 33
    tbl.push_back(vec_t'{0,0,3,0,0, 3,0,0,3,0,0,3,0,0,0});  // 34
    tbl.push_back(vec_t'{0,0,3,0,0, 4,0,0,4,0,0,3,0,1,0});  // 35
    tbl.push_back(vec_t'{0,0,3,0,0, 5,0,0,5,0,0,3,0,1,1});  // 36
    tbl.push_back(vec_t'{1,0,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 37 reset mid-game
    tbl.push_back(vec_t'{0,0,1,0,0, 0,0,0,0,0,0,0,1,0,0});  // 38 idle again
    tbl.push_back(vec_t'{0,1,0,0,0, 0,0,0,0,0,0,0,1,0,0});  // 39
    tbl.push_back(vec_t'{0,0,2,0,1, 1,0,1,0,0,0,2,0,0,0});  // 40 push+pop empty
    tbl.push_back(vec_t'{0,1,1,0,1, 0,0,0,0,0,0,0,1,0,0});  // 41 clear wins
    tbl.push_back(vec_t'{0,0,0,2,0, 0,0,0,0,2,1,0,1,0,0});  // 42 end, no round

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].ini, tbl[i].man, tbl[i].par, tbl[i].pop);
      chk($sformatf("vec%0d tot", i), int'(tot), tbl[i].tot);
      chk($sformatf("vec%0d p1", i), int'(p1), tbl[i].p1);
      chk($sformatf("vec%0d p2", i), int'(p2), tbl[i].p2);
      chk($sformatf("vec%0d pd", i), int'(pd), tbl[i].pd);
      chk($sformatf("vec%0d ris", i), int'(ris), tbl[i].ris);
      chk($sformatf("vec%0d fine", i), int'(fine), tbl[i].fine);
      chk($sformatf("vec%0d dato", i), int'(dato), tbl[i].dato);
      chk($sformatf("vec%0d vuoto", i), int'(vuoto), tbl[i].vu);
      chk($sformatf("vec%0d pieno", i), int'(pieno), tbl[i].pi);
      chk($sformatf("vec%0d perso", i), int'(perso), tbl[i].pe);
      if (i == 36) begin
        // Narrow counters must stop at 3 rather than wrap.
        chk("sat pareggi", int'(s_pd), 3);
        chk("sat manche_tot", int'(s_tot), 3);
        chk("sat p1", int'(s_p1), 0);
      end
`ifdef MORRA_TOTALI_EN
      if (i == 17 || i == 20) chk($sformatf("vec%0d partite_p1", i), int'(gp1), 1);
      if (i == 37) chk("vec37 partite_p1", int'(gp1), 0);
      if (i == 42) chk("vec42 partite_p2", int'(gp2), 1);
`endif
    end

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 600; n++) begin
      int r, ini, man, par, pop;
      r   = ($urandom_range(0, 63) == 0) ? 1 : 0;
      ini = ($urandom_range(0, 15) == 0) ? 1 : 0;
      man = $urandom_range(0, 3);
      par = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      pop = ($urandom_range(0, 2) == 0) ? 1 : 0;
      apply(r, ini, man, par, pop);
      check_model(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morra_tabellone.md
Name: morra_tabellone

Overview:
- Scoreboard stage directly downstream of the MorraCinese FSMD.
- Consumes the per-cycle round result MANCHE and the match result PARTITA.
- Keeps per-game tallies and the final result, plus a show-ahead history FIFO of round outcomes for the display/readout logic.
- Shares clk and INIZIO with the FSMD.

Parameters:
- CNT_W, 5: width of per-game counters; 5 covers the 16-round maximum.
- DEPTH, 16: history FIFO depth in entries; power of two, at least 2.
- TOT_W, 8: width of cross-game totals; used only with MORRA_TOTALI_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- INIZIO  in  1  new-game strobe, same signal driven to the FSMD.
- MANCHE  in  2  round result: 00 no valid round, 01 PRIMO wins, 10 SECONDO wins, 11 draw.
- PARTITA  in  2  match result: 00 in progress, 01 PRIMO wins, 10 SECONDO wins, 11 tie.
- STORICO_POP  in  1  history read strobe.
- MANCHE_TOT  out  CNT_W  valid rounds this game.
- VITTORIE_P1  out  CNT_W  rounds won by PRIMO.
- VITTORIE_P2  out  CNT_W  rounds won by SECONDO.
- PAREGGI  out  CNT_W  drawn rounds.
- RISULTATO  out  2  latched PARTITA code.
- FINE_PARTITA  out  1  high while in FINE.
- STORICO_DATO  out  2  FIFO head entry; 00 when empty.
- STORICO_VUOTO  out  1  FIFO empty.
- STORICO_PIENO  out  1  FIFO full.
- STORICO_PERSO  out  1  sticky flag: a push was dropped.

Behaviour:
- Clock and reset:
  - One clock (clk). rst is synchronous and active-high.
  - rst has priority over everything else.
  - On reset: state IDLE; all counters 0; RISULTATO=00; FINE_PARTITA=0; FIFO empty (VUOTO=1, PIENO=0, DATO=00); PERSO=0.
- Timing: all outputs are registered. An input sampled at edge k is visible after edge k, i.e. 1-cycle latency.
- States: IDLE, GIOCO, FINE.
- IDLE:
  - MANCHE and PARTITA are ignored.
  - INIZIO=1 → GIOCO; per-game counters, RISULTATO, FIFO and PERSO are cleared.
- GIOCO:
  - INIZIO=1 restarts: same clear as above, stay in GIOCO. Round inputs in that cycle are ignored.
  - Otherwise, if MANCHE≠00: MANCHE_TOT+1, plus exactly one of VITTORIE_P1 (01), VITTORIE_P2 (10) or PAREGGI (11) +1; MANCHE is pushed into the FIFO.
  - Otherwise, if PARTITA≠00: RISULTATO←PARTITA, FINE_PARTITA←1, → FINE.
  - If MANCHE≠00 and PARTITA≠00 in the same cycle, both take effect: the round is counted and pushed, and the game ends.
- FINE:
  - MANCHE and PARTITA are ignored; counters and RISULTATO hold.
  - FIFO reads remain allowed.
  - INIZIO=1 → GIOCO with clear; FINE_PARTITA←0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- FIFO:
  - Show-ahead: STORICO_DATO always equals the head entry.
  - Pop when STORICO_POP=1 and not empty. Pop when empty is ignored; no underflow state change.
  - Push when full without a simultaneous pop is dropped and sets PERSO. PERSO clears only on rst or INIZIO.
  - Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
  - Read and write pointers wrap modulo DEPTH. Full and empty are derived from an occupancy count.
  - INIZIO clear overrides a same-cycle pop and push.
- Reset mid-game: returns to IDLE. No result is latched and no FIFO content is kept.

Optional Feature:
- Macro: MORRA_TOTALI_EN.
- Defined: adds outputs PARTITE_P1, PARTITE_P2 and PARTITE_PARI, each TOT_W wide, saturating.
  - One of them increments on each GIOCO→FINE transition, chosen by PARTITA: 01, 10 or 11.
  - Cleared only by rst; INIZIO does not affect them.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then MANCHE=01, PARTITA=00 with INIZIO=0 for 3 cycles → all counters 0, state IDLE, STORICO_VUOTO=1.
- Game flow: INIZIO pulse, then MANCHE sequence 10,01,01,00,01 → MANCHE_TOT=4, VITTORIE_P1=3, VITTORIE_P2=1, PAREGGI=0; FIFO pops return 10,01,01,01, then VUOTO=1.
- End of game: MANCHE=01 and PARTITA=01 in the same cycle → counters include the round, RISULTATO=01, FINE_PARTITA=1 one cycle later. A following MANCHE=10 leaves VITTORIE_P2 unchanged.
- Restart: INIZIO=1 while in FINE → next cycle all per-game counters 0, RISULTATO=00, FINE_PARTITA=0, FIFO empty. With MORRA_TOTALI_EN, PARTITE_P1 stays 1.
- FIFO full with DEPTH=4: five pushes with no pops → PIENO=1, PERSO=1, pops return the first 4 entries. A push plus pop when full keeps PIENO=1 and appends the new entry.
- Saturation with CNT_W=2: five MANCHE=11 rounds → PAREGGI=3 and MANCHE_TOT=3, no wrap.
